// File: rtl/ddr3_port_arbiter.sv
// Two-port round-robin front end for a DDR3 memory controller user interface.
// Each port issues single-burst reads or writes. Reads are tagged with the
// issuing port in order, so that in-order read returns reach the right port.
module ddr3_port_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init_calib_complete,
  input  logic                         p0_req,
  input  logic                         p0_rd,
  input  logic [ADDR_W-1:0]            p0_addr,
  input  logic [DATA_W-1:0]            p0_wdata,
  output logic                         p0_gnt,
  output logic [DATA_W-1:0]            p0_rdata,
  output logic                         p0_rvalid,
  input  logic                         p1_req,
  input  logic                         p1_rd,
  input  logic [ADDR_W-1:0]            p1_addr,
  input  logic [DATA_W-1:0]            p1_wdata,
  output logic                         p1_gnt,
  output logic [DATA_W-1:0]            p1_rdata,
  output logic                         p1_rvalid,
  output logic [2:0]                   app_cmd,
  output logic                         app_cmd_en,
  output logic [ADDR_W-1:0]            app_addr,
  input  logic                         app_cmd_rdy,
  output logic [DATA_W-1:0]            app_wdf_data,
  output logic                         app_wdf_wren,
  output logic                         app_wdf_end,
  input  logic                         app_wdf_rdy,
  input  logic [DATA_W-1:0]            app_rd_data,
  input  logic                         app_rd_data_valid,
  output logic [$clog2(TAG_DEPTH):0]   rd_pending,
  output logic                         err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t               state_r;
  logic                 last_gnt_r;   // port granted most recently; also the tag of the command in flight
  logic                 is_rd_r;      // command in flight is a read
  logic [TAG_DEPTH-1:0] tag_mem_r;    // one port-id bit per outstanding read
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;

  logic                 tag_full_s;
  logic                 tag_empty_s;
  logic                 elig0_s;
  logic                 elig1_s;
  logic                 win_valid_s;
  logic                 win_port_s;
  logic                 win_rd_s;
  logic [ADDR_W-1:0]    win_addr_s;
  logic [DATA_W-1:0]    win_wdata_s;
  logic                 done_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 head_tag_s;

  // rd_pending doubles as the tag FIFO occupancy count
  assign tag_full_s  = (rd_pending == CNT_W'(TAG_DEPTH));
  assign tag_empty_s = (rd_pending == CNT_W'(0));

  // a read needs a free tag slot; writes never do
  assign elig0_s = p0_req & (~p0_rd | ~tag_full_s);
  assign elig1_s = p1_req & (~p1_rd | ~tag_full_s);

  // Round-robin pick: on a tie the port not granted last wins
  always_comb begin
    win_valid_s = 1'b0;
    win_port_s  = 1'b0;
    if (elig0_s && elig1_s) begin
      win_valid_s = 1'b1;
      win_port_s  = ~last_gnt_r;
    end else if (elig0_s) begin
      win_valid_s = 1'b1;
      win_port_s  = 1'b0;
    end else if (elig1_s) begin
      win_valid_s = 1'b1;
      win_port_s  = 1'b1;
    end else begin
      win_valid_s = 1'b0;
      win_port_s  = 1'b0;
    end
  end

  assign win_rd_s    = win_port_s ? p1_rd    : p0_rd;
  assign win_addr_s  = win_port_s ? p1_addr  : p0_addr;
  assign win_wdata_s = win_port_s ? p1_wdata : p0_wdata;

  // reads need only the command slot; writes need command and data slots together
  assign done_s     = (state_r == ST_ISSUE) & app_cmd_rdy & (is_rd_r | app_wdf_rdy);
  assign push_s     = done_s & is_rd_r;
  assign pop_s      = app_rd_data_valid & ~tag_empty_s;
  assign head_tag_s = tag_mem_r[rd_ptr_r];

  // Command FSM: grant in IDLE, hold the command on the MC interface in ISSUE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_gnt_r   <= 1'b1;
      is_rd_r      <= 1'b0;
      p0_gnt       <= 1'b0;
      p1_gnt       <= 1'b0;
      app_cmd      <= 3'b000;
      app_cmd_en   <= 1'b0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
    end else begin
      p0_gnt <= 1'b0;
      p1_gnt <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (init_calib_complete && win_valid_s) begin
            state_r      <= ST_ISSUE;
            last_gnt_r   <= win_port_s;
            is_rd_r      <= win_rd_s;
            p0_gnt       <= ~win_port_s;
            p1_gnt       <= win_port_s;
            app_cmd      <= win_rd_s ? 3'b001 : 3'b000;
            app_cmd_en   <= 1'b1;
            app_addr     <= win_addr_s;
            app_wdf_data <= win_wdata_s;
            app_wdf_wren <= ~win_rd_s;
            app_wdf_end  <= ~win_rd_s;
          end
        end
        ST_ISSUE: begin
          // calibration loss does not abort a command already on the bus
          if (done_s) begin
            state_r      <= ST_IDLE;
            app_cmd_en   <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          app_cmd_en   <= 1'b0;
          app_wdf_wren <= 1'b0;
          app_wdf_end  <= 1'b0;
        end
      endcase
    end
  end

  // Tag FIFO, read-data steering to the owning port and the orphan-return flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_mem_r  <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      rd_pending <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= last_gnt_r;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        if (head_tag_s) begin
          p1_rdata  <= app_rd_data;
          p1_rvalid <= 1'b1;
        end else begin
          p0_rdata  <= app_rd_data;
          p0_rvalid <= 1'b1;
        end
      end
      if (app_rd_data_valid && tag_empty_s) begin
        err <= 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   rd_pending <= rd_pending + CNT_W'(1);
        2'b01:   rd_pending <= rd_pending - CNT_W'(1);
        default: rd_pending <= rd_pending;
      endcase
    end
  end

endmodule
